// File: rtl/lieat_csa_tree_pipe.sv
// lieat_csa_tree_pipe
//   Pipelined multi-operand carry-save reduction tree. NUM_OPS operands of
//   WIDTH bits are reduced level by level with 3:2 compressors until a single
//   sum/carry pair remains. A pipeline register follows every REG_EVERY
//   levels (and the last level). When FINAL_ADD=1 an extra registered stage
//   resolves the pair into result_o. Both sides use a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush_i    synchronous flush: drops every in-flight vector
//   in_valid   operand vector valid
//   in_ready   tree accepts operand vector
//   ops_i      operand k at ops_i[k*WIDTH +: WIDTH]
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum_o      carry-save sum of the final tree level
//   carry_o    carry-save carry of the final tree level (bit 0 always 0)
//   result_o   sum_o + carry_o mod 2^WIDTH (0 when FINAL_ADD=0)
//
// Legal ranges: WIDTH >= 2, NUM_OPS 3..16, REG_EVERY 1..6, FINAL_ADD 0/1.

module lieat_csa_tree_pipe #(
  parameter int WIDTH     = 16,
  parameter int NUM_OPS   = 8,
  parameter int REG_EVERY = 2,
  parameter int FINAL_ADD = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*WIDTH-1:0] ops_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         sum_o,
  output logic [WIDTH-1:0]         carry_o,
  output logic [WIDTH-1:0]         result_o
);

  // Live operand count after k reduction levels.
  function automatic int cnt_at(input int k);
    int n;
    n = NUM_OPS;
    for (int i = 0; i < k; i++) n = 2 * (n / 3) + (n % 3);
    return n;
  endfunction

  function automatic int calc_levels();
    int n;
    int l;
    n = NUM_OPS;
    l = 0;
    for (int i = 0; i < 32; i++) begin
      if (n > 2) begin
        n = 2 * (n / 3) + (n % 3);
        l++;
      end
    end
    return l;
  endfunction

  localparam int L   = calc_levels();
  localparam int S   = (L + REG_EVERY - 1) / REG_EVERY;
  localparam int NST = S + ((FINAL_ADD != 0) ? 1 : 0);

  // Number of levels completed at the output of tree register stage s.
  function automatic int stage_end(input int s);
    return ((s + 1) * REG_EVERY < L) ? (s + 1) * REG_EVERY : L;
  endfunction

  // Bit offset of level l's output inside the flattened level bus.
  function automatic int lvl_off(input int l);
    int o;
    o = 0;
    for (int i = 0; i < l; i++) o += cnt_at(i + 1) * WIDTH;
    return o;
  endfunction

  // Bit offset of tree stage s's register inside the flattened register bus.
  function automatic int reg_off(input int s);
    int o;
    o = 0;
    for (int i = 0; i < s; i++) o += cnt_at(stage_end(i)) * WIDTH;
    return o;
  endfunction

  localparam int LTOT = lvl_off(L);
  localparam int RTOT = reg_off(S);

  // Every level's combinational output and every stage register are packed
  // into two flat buses; the operand count shrinks per level so a uniform
  // array would leave dead bits behind.
  wire [LTOT-1:0] lvl_bus;
  wire [RTOT-1:0] reg_bus;

  logic [NST-1:0] v;
  logic [NST-1:0] rdy;
  logic [NST-1:0] vin;
  logic [NST-1:0] load;

  // ------------------------------------------------------------------
  // Handshake: stage k is ready if it is empty or anything downstream of
  // it (including the consumer) can move. Written in closed form so the
  // ready chain has no self-referencing vector.
  // ------------------------------------------------------------------
  always_comb begin
    rdy = '0;
    for (int k = 0; k < NST; k++) begin
      rdy[k] = out_ready;
      for (int j = k; j < NST; j++) begin
        if (!v[j]) rdy[k] = 1'b1;
      end
    end
  end

  assign in_ready = rdy[0] & ~flush_i;

  always_comb begin
    vin    = '0;
    vin[0] = in_valid & in_ready;
    for (int k = 1; k < NST; k++) vin[k] = v[k-1];
    // Flush must not disturb data registers, so it also blocks loads.
    load = rdy & vin & {NST{~flush_i}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else if (flush_i) begin
      v <= '0;
    end else begin
      for (int k = 0; k < NST; k++) begin
        if (rdy[k]) v[k] <= vin[k];
      end
    end
  end

  assign out_valid = v[NST-1];

  // ------------------------------------------------------------------
  // Compressor levels. Triples are taken from index 0 upward; each triple
  // yields (sum, carry) in that order, leftovers follow unchanged. The
  // last level always sees exactly three operands, so its output is
  // element 0 = sum, element 1 = carry.
  // ------------------------------------------------------------------
  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int NIN  = cnt_at(l);
    localparam int NG   = NIN / 3;
    localparam int OOFF = lvl_off(l);

    wire [NIN*WIDTH-1:0] li;

    if (l == 0) begin : g_src_in
      assign li = ops_i;
    end else if ((l % REG_EVERY) == 0) begin : g_src_reg
      assign li = reg_bus[reg_off(l / REG_EVERY - 1) +: NIN*WIDTH];
    end else begin : g_src_lvl
      assign li = lvl_bus[lvl_off(l - 1) +: NIN*WIDTH];
    end

    for (genvar g = 0; g < NG; g++) begin : g_csa
      wire [WIDTH-1:0] a = li[(3*g)*WIDTH   +: WIDTH];
      wire [WIDTH-1:0] b = li[(3*g+1)*WIDTH +: WIDTH];
      wire [WIDTH-1:0] c = li[(3*g+2)*WIDTH +: WIDTH];

      assign lvl_bus[OOFF + (2*g)*WIDTH +: WIDTH] = a ^ b ^ c;
      // Majority shifted left by one; the MSB carry falls off (mod 2^WIDTH).
      assign lvl_bus[OOFF + (2*g+1)*WIDTH +: WIDTH] =
        {(a[WIDTH-2:0] & b[WIDTH-2:0]) |
         (a[WIDTH-2:0] & c[WIDTH-2:0]) |
         (b[WIDTH-2:0] & c[WIDTH-2:0]), 1'b0};
    end

    for (genvar r = 0; r < NIN - 3*NG; r++) begin : g_pass
      assign lvl_bus[OOFF + (2*NG+r)*WIDTH +: WIDTH] = li[(3*NG+r)*WIDTH +: WIDTH];
    end
  end

  // ------------------------------------------------------------------
  // Tree pipeline registers. Data only moves on a handshake into the
  // stage; bubbles keep stale data, which is harmless behind valid.
  // ------------------------------------------------------------------
  for (genvar s = 0; s < S; s++) begin : g_stg
    localparam int LAST = stage_end(s) - 1;
    localparam int NW   = cnt_at(LAST + 1) * WIDTH;

    logic [NW-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (load[s]) begin
        q <= lvl_bus[lvl_off(LAST) +: NW];
      end
    end

    assign reg_bus[reg_off(s) +: NW] = q;
  end

  wire [WIDTH-1:0] tree_sum   = reg_bus[reg_off(S-1)         +: WIDTH];
  wire [WIDTH-1:0] tree_carry = reg_bus[reg_off(S-1) + WIDTH +: WIDTH];

  if (FINAL_ADD != 0) begin : g_fadd
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic [WIDTH-1:0] result_q;

    // sum/carry travel with the result so all three outputs stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q    <= '0;
        carry_q  <= '0;
        result_q <= '0;
      end else if (load[S]) begin
        sum_q    <= tree_sum;
        carry_q  <= tree_carry;
        result_q <= tree_sum + tree_carry;
      end
    end

    assign sum_o    = sum_q;
    assign carry_o  = carry_q;
    assign result_o = result_q;
  end else begin : g_nofadd
    assign sum_o    = tree_sum;
    assign carry_o  = tree_carry;
    assign result_o = '0;
  end

endmodule

// File: tb/tb_lieat_csa_tree_pipe.sv
module tb_lieat_csa_tree_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // default configuration: 8 x 16, REG_EVERY=2, FINAL_ADD=1 (latency 3)
  logic         flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [127:0] ops_a;
  logic [15:0]  sum_a, carry_a, result_a;

  // small configuration: 3 x 16, REG_EVERY=1, FINAL_ADD=0 (latency 1)
  logic         flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [47:0]  ops_b;
  logic [15:0]  sum_b, carry_b, result_b;

  lieat_csa_tree_pipe dut_a (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .ops_i(ops_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .sum_o(sum_a), .carry_o(carry_a), .result_o(result_a)
  );

  lieat_csa_tree_pipe #(.WIDTH(16), .NUM_OPS(3), .REG_EVERY(1), .FINAL_ADD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .ops_i(ops_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .sum_o(sum_b), .carry_o(carry_b), .result_o(result_b)
  );

  typedef struct {
    logic [15:0] exp;
    int          acc;
    int          lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] fill(input logic [15:0] base, input logic [15:0] step);
    logic [127:0] v;
    for (int k = 0; k < 8; k++) v[k*16 +: 16] = base + 16'(k) * step;
    return v;
  endfunction

  function automatic logic [15:0] msum(input logic [127:0] v);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) s = s + v[k*16 +: 16];
    return s;
  endfunction

  // Monitors sample 3 time units after the falling edge, i.e. just before
  // the rising edge on which an output handshake would complete.
  always begin : mon_a
    exp_t e;
    @(negedge clk);
    #3;
    if (rst_n && out_valid_a && out_ready_a && !flush_a) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_out", 32'd1, 32'd0);
      end else begin
        e = qa.pop_front();
        chk("a_result", result_a, e.exp);
        chk("a_sum_plus_carry", 16'(sum_a + carry_a), e.exp);
        chk("a_carry_lsb", carry_a[0], 1'b0);
        if (e.lat >= 0) chk("a_latency", cyc - e.acc, e.lat);
      end
    end
  end

  always begin : mon_b
    exp_t e;
    @(negedge clk);
    #3;
    if (rst_n && out_valid_b && out_ready_b && !flush_b) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_out", 32'd1, 32'd0);
      end else begin
        e = qb.pop_front();
        chk("b_sum_plus_carry", 16'(sum_b + carry_b), e.exp);
        chk("b_result_tied0", result_b, 16'h0000);
        chk("b_carry_lsb", carry_b[0], 1'b0);
        if (e.lat >= 0) chk("b_latency", cyc - e.acc, e.lat);
      end
    end
  end

  // Called on a falling edge; returns on a falling edge after acceptance.
  task automatic send_a(input logic [127:0] v, input logic [15:0] exp, input int lat,
                        input bit must);
    int   n;
    bit   acc;
    exp_t e;
    in_valid_a = 1'b1;
    ops_a      = v;
    acc        = 1'b0;
    n          = 0;
    while (!acc && n < (must ? 1 : 30)) begin
      #1;
      if (in_ready_a) begin
        e.exp = exp; e.acc = cyc; e.lat = lat;
        qa.push_back(e);
        acc = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    chk(must ? "a_in_ready_accept" : "a_accept_timeout", acc, 1'b1);
    in_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [47:0] v, input logic [15:0] exp, input int lat);
    exp_t e;
    in_valid_b = 1'b1;
    ops_b      = v;
    #1;
    chk("b_in_ready_accept", in_ready_b, 1'b1);
    if (in_ready_b) begin
      e.exp = exp; e.acc = cyc; e.lat = lat;
      qb.push_back(e);
    end
    @(negedge clk);
    in_valid_b = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", qa.size() + qb.size(), 32'd0);
  endtask

  initial begin : main
    logic [127:0] v;
    int           idx;

    rst_n = 1'b0;
    flush_a = 1'b0; in_valid_a = 1'b0; ops_a = '0; out_ready_a = 1'b1;
    flush_b = 1'b0; in_valid_b = 1'b0; ops_b = '0; out_ready_b = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid_a", out_valid_a, 1'b0);
    chk("rst_sum_a", sum_a, 16'h0);
    chk("rst_carry_a", carry_a, 16'h0);
    chk("rst_result_a", result_a, 16'h0);
    chk("rst_out_valid_b", out_valid_b, 1'b0);
    chk("rst_sum_b", sum_b, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready_a", in_ready_a, 1'b1);
    chk("post_rst_in_ready_b", in_ready_b, 1'b1);
    @(negedge clk);

    // 1: ops 1..8 -> 36
    send_a(fill(16'd1, 16'd1), 16'h0024, 3, 1'b1);
    wait_drain();

    // 2: all ones wrap
    send_a(fill(16'hFFFF, 16'd0), 16'hFFF8, 3, 1'b1);
    wait_drain();

    // 3: back-to-back stream, every vector must be taken on its first cycle
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 8; k++) v[k*16 +: 16] = 16'($urandom);
      send_a(v, msum(v), 3, 1'b1);
    end
    wait_drain();
    @(negedge clk);

    // 4: backpressure fills three stages then stalls
    out_ready_a = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid_a = 1'b1;
      ops_a      = fill(16'(idx + 1), 16'd0);
      #1;
      if (in_ready_a) begin
        qa.push_back('{exp: 16'(8 * (idx + 1)), acc: cyc, lat: -1});
        idx++;
      end
      @(negedge clk);
    end
    in_valid_a = 1'b0;
    #1;
    chk("stall_accepted", idx, 32'd3);
    chk("stall_in_ready", in_ready_a, 1'b0);
    chk("stall_out_valid", out_valid_a, 1'b1);
    chk("stall_result", result_a, 16'h0008);
    repeat (2) @(negedge clk);
    #1;
    chk("stall_result_hold", result_a, 16'h0008);
    chk("stall_sum_carry_hold", 16'(sum_a + carry_a), 16'h0008);
    chk("stall_out_valid_hold", out_valid_a, 1'b1);
    @(negedge clk);
    out_ready_a = 1'b1;
    wait_drain();
    @(negedge clk);

    // 5: flush with three in flight plus a same-cycle vector
    for (int i = 0; i < 3; i++) send_a(fill(16'(16'h0100 * (i + 1)), 16'd3), 16'h0, 3, 1'b1);
    in_valid_a = 1'b1;
    ops_a      = fill(16'hAAAA, 16'd0);
    flush_a    = 1'b1;
    #1;
    chk("flush_in_ready", in_ready_a, 1'b0);
    qa.delete();
    @(negedge clk);
    flush_a    = 1'b0;
    in_valid_a = 1'b0;
    #1;
    chk("flush_out_valid", out_valid_a, 1'b0);
    repeat (5) @(negedge clk);
    send_a(fill(16'h1234, 16'd1), 16'h91BC, 3, 1'b1);
    wait_drain();

    // 6: reset mid-stream, then small configuration
    for (int i = 0; i < 4; i++) send_a(fill(16'(i + 2), 16'd0), 16'(8 * (i + 2)), 3, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid_a, 1'b0);
    chk("midrst_sum", sum_a, 16'h0);
    chk("midrst_carry", carry_a, 16'h0);
    chk("midrst_result", result_a, 16'h0);
    qa.delete();
    qb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send_b({16'd7, 16'd6, 16'd5}, 16'd18, 1);
    send_b({16'h0003, 16'hFFFF, 16'hFFFF}, 16'h0001, 1);
    send_a(fill(16'd1, 16'd1), 16'h0024, 3, 1'b1);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
